// File: rtl/prng_lfsr_core.sv
// prng_lfsr_core: 16-bit Galois LFSR pseudo-random word source.
//   A 16-bit seed is loaded as two bytes, low byte first. start begins
//   generation and stop ends it. Words are handed off through a
//   valid/ready handshake. The LFSR state survives a stop, so a later
//   start resumes the same sequence.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   seed_data   seed byte (low byte first)
//   seed_valid  seed_data valid this cycle
//   seed_ready  block accepts a seed byte (IDLE / SEED_HI)
//   start       begin generating (honoured in IDLE only)
//   stop        halt generating (honoured in RUN only)
//   rand_out    current LFSR word
//   rand_valid  rand_out valid (RUN only)
//   rand_ready  consumer takes rand_out this cycle
//   count       words accepted since the last seed load (wraps)
//   busy        FSM is in RUN
module prng_lfsr_core #(
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  seed_data,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] rand_out,
  output logic        rand_valid,
  input  logic        rand_ready,
  output logic [15:0] count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEED_HI, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] seed_w;
  logic [15:0] step_w;

  assign seed_w = {seed_data, lo_q};
  // Galois step: shift right, fold the taps back in when bit 0 falls out.
  assign step_w = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= 16'h0001;
      lo_q    <= 8'h00;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // A seed byte wins over a simultaneous start.
        if (seed_valid) begin
          lo_d    = seed_data;
          state_d = SEED_HI;
        end else if (start) begin
          state_d = RUN;
        end
      end
      SEED_HI: begin
        if (seed_valid) begin
          // An all-zero seed would lock the LFSR, so substitute 1.
          lfsr_d  = (seed_w == 16'h0000) ? 16'h0001 : seed_w;
          count_d = 16'h0000;
          state_d = IDLE;
        end
      end
      RUN: begin
        // The handshake completes even when stop arrives in the same cycle.
        if (rand_ready) begin
          lfsr_d  = step_w;
          count_d = count_q + 16'd1;
        end
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign seed_ready = (state_q != RUN);
  assign rand_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign rand_out   = lfsr_q;
  assign count      = count_q;

endmodule

// File: tb/tb_prng_lfsr_core.sv
// Directed bench for prng_lfsr_core: seed load, sequence, backpressure,
// stop/restart, zero-seed protection, reset priority and full period.
module tb_prng_lfsr_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seed_data = 8'h00;
  logic        seed_valid = 1'b0;
  logic        seed_ready;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rand_out;
  logic        rand_valid;
  logic        rand_ready = 1'b0;
  logic [15:0] count;
  logic        busy;

  int total = 0;
  int bad = 0;

  prng_lfsr_core dut (
    .clock(clock), .reset(reset),
    .seed_data(seed_data), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .start(start), .stop(stop),
    .rand_out(rand_out), .rand_valid(rand_valid), .rand_ready(rand_ready),
    .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_seed(input logic [7:0] lo, input logic [7:0] hi);
    seed_valid = 1'b1; seed_data = lo; tick();
    seed_data = hi; tick();
    seed_valid = 1'b0;
  endtask

  logic [15:0] seq_a [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
  logic [15:0] hold_v, hold_c;
  int zeros, early;

  initial begin
    // Reset state
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    chk("rst_valid", rand_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sready", seed_ready, 1);
    chk("rst_out", rand_out, 16'h0001);
    chk("rst_count", count, 0);

    // Seed E1,AC then run with ready held high
    seed_valid = 1'b1; seed_data = 8'hE1; tick();
    chk("seedhi_sready", seed_ready, 1);
    chk("seedhi_busy", busy, 0);
    seed_data = 8'hAC; start = 1'b1; tick();   // start ignored in SEED_HI
    seed_valid = 1'b0; start = 1'b0;
    chk("seeded_busy", busy, 0);
    chk("seeded_out", rand_out, 16'hACE1);
    start = 1'b1; tick(); start = 1'b0;
    chk("run_valid", rand_valid, 1);
    chk("run_sready", seed_ready, 0);
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_out%0d", i), rand_out, seq_a[i]);
      chk($sformatf("seq_cnt%0d", i), count, i);
      if (i < 3) tick();
    end

    // Backpressure: 5 cycles with ready low
    rand_ready = 1'b0;
    hold_v = rand_out; hold_c = count;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out", rand_out, 16'h389C);
      chk("bp_cnt", count, 3);
      chk("bp_valid", rand_valid, 1);
    end

    // Stop coinciding with a handshake
    rand_ready = 1'b1; stop = 1'b1; tick();
    rand_ready = 1'b0; stop = 1'b0;
    chk("stop_out", rand_out, 16'h1C4E);
    chk("stop_cnt", count, 4);
    chk("stop_valid", rand_valid, 0);
    chk("stop_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("resume_out", rand_out, 16'h1C4E);
    rand_ready = 1'b1; tick(); rand_ready = 1'b0;
    chk("resume_next", rand_out, 16'h0E27);
    chk("resume_cnt", count, 5);
    stop = 1'b1; tick(); stop = 1'b0;

    // Zero seed -> 0001, B400, 5A00
    send_seed(8'h00, 8'h00);
    chk("zs_out", rand_out, 16'h0001);
    chk("zs_cnt", count, 0);
    start = 1'b1; tick(); start = 1'b0;
    rand_ready = 1'b1;
    chk("zs_run0", rand_out, 16'h0001);
    tick(); chk("zs_run1", rand_out, 16'hB400);
    tick(); chk("zs_run2", rand_out, 16'h5A00);
    rand_ready = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

    // Reset in SEED_HI, with a seed byte still offered
    seed_valid = 1'b1; seed_data = 8'h55; tick();
    seed_data = 8'h77; reset = 1'b1; tick(); reset = 1'b0; seed_valid = 1'b0;
    chk("rsh_out", rand_out, 16'h0001);
    chk("rsh_cnt", count, 0);
    chk("rsh_sready", seed_ready, 1);
    chk("rsh_busy", busy, 0);
    // The next byte must be taken as a low byte again
    send_seed(8'h34, 8'h12);
    chk("rsh_reseed", rand_out, 16'h1234);

    // Reset in RUN
    start = 1'b1; tick(); start = 1'b0;
    rand_ready = 1'b1; tick(); tick();
    chk("rrun_cnt_pre", count, 2);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0; rand_ready = 1'b0;
    chk("rrun_out", rand_out, 16'h0001);
    chk("rrun_cnt", count, 0);
    chk("rrun_sready", seed_ready, 1);
    chk("rrun_valid", rand_valid, 0);

    // Full period from seed 0001
    send_seed(8'h01, 8'h00);
    start = 1'b1; tick(); start = 1'b0;
    rand_ready = 1'b1;
    zeros = 0; early = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (rand_out == 16'h0000) zeros++;
      if (i < 65535 && rand_out == 16'h0001) early++;
    end
    rand_ready = 1'b0;
    chk("per_zero", zeros, 0);
    chk("per_early", early, 0);
    chk("per_out", rand_out, 16'h0001);
    chk("per_cnt", count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prng_lfsr_core.md
PRNG_LFSR_CORE -- requirements
Module: prng_lfsr_core

Interface
REQ-001 SHALL have parameter TAPS, default 16'hB400, the Galois feedback mask for the maximal-length polynomial x^16+x^14+x^13+x^11+1.
REQ-002 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port seed_data, input, 8 bits: seed byte, low byte first.
REQ-005 SHALL have port seed_valid, input, 1 bit: seed_data is valid this cycle.
REQ-006 SHALL have port seed_ready, output, 1 bit: block accepts a seed byte this cycle.
REQ-007 SHALL have port start, input, 1 bit: request to begin generating.
REQ-008 SHALL have port stop, input, 1 bit: request to halt generating.
REQ-009 SHALL have port rand_out, output, 16 bits: current pseudo-random word.
REQ-010 SHALL have port rand_valid, output, 1 bit: rand_out is valid.
REQ-011 SHALL have port rand_ready, input, 1 bit: consumer accepts rand_out this cycle.
REQ-012 SHALL have port count, output, 16 bits: number of words accepted since the last seed load, wrapping at 16'hFFFF.
REQ-013 SHALL have port busy, output, 1 bit: high exactly when the FSM is in RUN.

Function
REQ-014 SHALL implement an FSM with states IDLE, SEED_HI and RUN, all with registered state.
REQ-015 SHALL drive seed_ready to 1 in IDLE and SEED_HI and to 0 in RUN, decoded from state only.
REQ-016 In IDLE, seed_valid&seed_ready SHALL capture seed_data into a holding low byte and move the FSM to SEED_HI.
REQ-017 In SEED_HI, seed_valid SHALL capture seed_data as the high byte and return the FSM to IDLE.
REQ-018 In that same SEED_HI cycle, the LFSR SHALL load {high,low}, with count cleared to 0.
REQ-019 An assembled seed of 16'h0000 SHALL instead load 16'h0001 (zero-lock protection).
REQ-020 In IDLE with seed_valid=0, start SHALL move the FSM to RUN, with rand_valid=1 from the next cycle.
REQ-021 In IDLE, seed_valid=1 and start=1 together SHALL take the seed byte and ignore start.
REQ-022 start SHALL be ignored in SEED_HI and in RUN.
REQ-023 rand_out SHALL equal the LFSR register at all times; rand_valid SHALL be 1 only in RUN.
REQ-024 On rand_valid&rand_ready, the LFSR SHALL advance one step on that clock edge and count SHALL increment by 1 modulo 2^16.
REQ-025 The step SHALL be: if lfsr[0]=1, next=(lfsr>>1)^TAPS; else next=lfsr>>1.
REQ-026 Throughput SHALL be one word per cycle while rand_ready is held high.
REQ-027 While rand_valid=1 and rand_ready=0, rand_out and count SHALL hold stable.
REQ-028 stop in RUN SHALL move the FSM to IDLE, with rand_valid=0 from the next cycle.
REQ-029 If stop coincides with a handshake, the handshake SHALL complete, meaning the LFSR advances and count increments.
REQ-030 stop SHALL be ignored outside RUN.
REQ-031 The LFSR SHALL keep its value across RUN->IDLE->RUN, so generation resumes where it stopped.
REQ-032 The LFSR SHALL never reach 16'h0000 and SHALL have a period of 65535.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL set state=IDLE, lfsr=16'h0001, low byte holding register=8'h00 and count=16'h0000.
REQ-034 Directly after reset, the outputs SHALL be rand_valid=0, busy=0, seed_ready=1 and rand_out=16'h0001.
REQ-035 reset SHALL take priority over every other input in every state, including mid-seed (SEED_HI) and mid-run.

Verification
REQ-036 Bench SHALL cover: seed bytes E1 then AC, start, rand_ready=1 -> rand_out sequence ACE1, E270, 7138, 389C; count 0,1,2,3.
REQ-037 Bench SHALL cover: seed bytes 00, 00, start -> rand_out 0001 then B400, never 0000.
REQ-038 Bench SHALL cover: in RUN, rand_ready=0 for 5 cycles -> rand_out and count constant, rand_valid=1 throughout.
REQ-039 Bench SHALL cover: stop and handshake in the same cycle -> LFSR advances once, count+1, rand_valid=0 next cycle; restart continues the sequence.
REQ-040 Bench SHALL cover: reset asserted in SEED_HI and in RUN -> next cycle state=IDLE, rand_out=0001, count=0, seed_ready=1.
REQ-041 Bench SHALL cover: seed 0001, 65535 handshakes -> rand_out returns to 0001, 0000 never seen, count=FFFF.
